// File: rtl/resta_pkg.sv
// Shared types and constants for the serial subtractor.
package resta_pkg;

  // Controller states: waiting for operands, slicing, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } estado_t;

  // Bit positions inside the banderas flag nibble.
  localparam int BAND_N = 3;
  localparam int BAND_Z = 2;
  localparam int BAND_C = 1;
  localparam int BAND_V = 0;

endpackage

// File: rtl/resta_bloque.sv
// Combinational W-bit slice subtractor: d = a - b - borrow_in,
// with borrow-out and a flag telling whether the slice result is zero.
module resta_bloque #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         borrow_in,
  output logic [W-1:0] d,
  output logic         borrow_out,
  output logic         zero
);

  logic [W:0] ext;

  // Widen by one bit so the top bit of the difference is the borrow-out.
  always_comb begin
    ext        = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, borrow_in};
    d          = ext[W-1:0];
    borrow_out = ext[W];
    zero       = (ext[W-1:0] == '0);
  end

endmodule

// File: rtl/resta_serie.sv
// Multi-cycle N-bit subtractor processing one W-bit slice per clock,
// least significant slice first, with valid/ready on both sides.
// Optional macro RESTA_SBC_EN adds acarreo_in (ARM SBC: a - b - !C).
module resta_serie
  import resta_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  output logic         ready_out,
`ifdef RESTA_SBC_EN
  input  logic         acarreo_in,
`endif
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         valid_out,
  input  logic         ready_in,
  output logic [N-1:0] c,
  output logic [3:0]   banderas
);

  localparam int K  = N / W;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  estado_t       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          borrow_q, borrow_d;
  logic          zacc_q, zacc_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  c_q, c_d;
  logic [3:0]    band_q, band_d;
  logic          valid_q, valid_d;

  logic [W-1:0]  sl_a, sl_b, sl_d;
  logic          sl_bout, sl_zero;
  logic          borrow_init;

`ifdef RESTA_SBC_EN
  assign borrow_init = ~acarreo_in;
`else
  assign borrow_init = 1'b0;
`endif

  // The current slice of each latched operand feeds the single shared slice unit.
  assign sl_a = a_q[int'(cnt_q) * W +: W];
  assign sl_b = b_q[int'(cnt_q) * W +: W];

  resta_bloque #(.W(W)) u_bloque (
    .a          (sl_a),
    .b          (sl_b),
    .borrow_in  (borrow_q),
    .d          (sl_d),
    .borrow_out (sl_bout),
    .zero       (sl_zero)
  );

  // Next-state logic: accept, slice-by-slice subtract, then hold until consumed.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    zacc_d   = zacc_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    band_d   = band_q;
    valid_d  = valid_q;
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          a_d      = a;
          b_d      = b;
          cnt_d    = '0;
          borrow_d = borrow_init;
          zacc_d   = 1'b1;
          state_d  = CALC;
        end
      end
      CALC: begin
        c_d[int'(cnt_q) * W +: W] = sl_d;
        borrow_d = sl_bout;
        zacc_d   = zacc_q & sl_zero;
        if (cnt_q == LAST) begin
          // Final slice: its top bit is the result sign, its borrow the final borrow.
          band_d[BAND_N] = sl_d[W-1];
          band_d[BAND_Z] = zacc_q & sl_zero;
          band_d[BAND_C] = ~sl_bout;
          band_d[BAND_V] = (a_q[N-1] != b_q[N-1]) & (sl_d[W-1] != a_q[N-1]);
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (ready_in) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      zacc_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      band_q   <= 4'b0000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      zacc_q   <= zacc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      band_q   <= band_d;
      valid_q  <= valid_d;
    end
  end

  assign ready_out = (state_q == IDLE);
  assign valid_out = valid_q;
  assign c         = c_q;
  assign banderas  = band_q;

endmodule

// File: tb/tb_resta_serie.sv
// Directed self-checking bench for resta_serie with N=16, W=4 (K=4).
module tb_resta_serie;

  localparam int N = 16;
  localparam int W = 4;
  localparam int K = N / W;

  logic         clk;
  logic         rst;
  logic         valid_in;
  logic         ready_out;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         valid_out;
  logic         ready_in;
  logic [N-1:0] c;
  logic [3:0]   banderas;
`ifdef RESTA_SBC_EN
  logic         acarreo_in;
`endif

  int checks;
  int errors;

  resta_serie #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
`ifdef RESTA_SBC_EN
    .acarreo_in (acarreo_in),
`endif
    .a          (a),
    .b          (b),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .c          (c),
    .banderas   (banderas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands for one accept edge; returns edges counted until valid_out.
  task automatic start_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                          output int lat);
    @(negedge clk);
    a = av;
    b = bv;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (valid_out) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++;
    if (c !== 16'h0000 || banderas !== 4'b0000 || valid_out !== 1'b0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset: c=%h band=%b vo=%b ro=%b required c=0000 band=0000 vo=0 ro=1",
               c, banderas, valid_out, ready_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("reset: c=%h band=%b vo=%b ro=%b", c, banderas, valid_out, ready_out);
  endtask

  task automatic test_sub(input logic [N-1:0] av, input logic [N-1:0] bv,
                          input logic [N-1:0] ce, input logic [3:0] fe);
    int lat;
    start_op(av, bv, lat);
    checks++;
    if (lat !== K || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL latency %h-%h: got %0d edges vo=%b required %0d edges vo=1", av, bv, lat, valid_out, K);
    end
    checks++;
    if (c !== ce || banderas !== fe) begin
      errors++;
      $display("FAIL result %h-%h: c=%h band=%b required c=%h band=%b", av, bv, c, banderas, ce, fe);
    end
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("FAIL ready_out in DONE: got %b required 0", ready_out);
    end
    @(negedge clk);
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    ready_in = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL release %h-%h: vo=%b ro=%b required vo=0 ro=1", av, bv, valid_out, ready_out);
    end
    $display("sub %h - %h: c=%h band=%b lat=%0d", av, bv, c, banderas, lat);
  endtask

  task automatic test_hold;
    int lat;
    start_op(16'h0003, 16'h0005, lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid_in = ~valid_in;
      a = 16'h0F0F + 16'(i);
      b = 16'h0001;
      @(posedge clk);
      #1;
      checks++;
      if (c !== 16'hFFFE || banderas !== 4'b1000 || valid_out !== 1'b1 || ready_out !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d: c=%h band=%b vo=%b ro=%b required c=fffe band=1000 vo=1 ro=0",
                 i, c, banderas, valid_out, ready_out);
      end
    end
    @(negedge clk);
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    ready_in = 1'b0;
    checks++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL hold release: ro=%b vo=%b required ro=1 vo=0", ready_out, valid_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL hold no stray accept: ro=%b required 1", ready_out);
    end
    $display("hold: c=%h band=%b ro=%b", c, banderas, ready_out);
  endtask

  task automatic test_abort;
    int seen;
    @(negedge clk);
    a = 16'h0005;
    b = 16'h0003;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (c[3:0] !== 4'h2) begin
      errors++;
      $display("FAIL partial slice0: c=%h required low nibble 2", c);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (c !== 16'h0000 || banderas !== 4'b0000 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL abort: c=%h band=%b vo=%b required c=0000 band=0000 vo=0", c, banderas, valid_out);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL abort ready: ro=%b required 1", ready_out);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (valid_out) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort no result: valid_out seen %0d cycles required 0", seen);
    end
    $display("abort: c=%h band=%b ro=%b", c, banderas, ready_out);
  endtask

`ifdef RESTA_SBC_EN
  task automatic test_sbc;
    acarreo_in = 1'b0;
    test_sub(16'h0005, 16'h0003, 16'h0001, 4'b0010);
    acarreo_in = 1'b1;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    a = '0;
    b = '0;
`ifdef RESTA_SBC_EN
    acarreo_in = 1'b1;
`endif
    test_reset;
    test_sub(16'h0005, 16'h0003, 16'h0002, 4'b0010);
    test_sub(16'h0003, 16'h0005, 16'hFFFE, 4'b1000);
    test_sub(16'h1234, 16'h1234, 16'h0000, 4'b0110);
    test_sub(16'h8000, 16'h0001, 16'h7FFF, 4'b0011);
    test_hold;
    test_abort;
`ifdef RESTA_SBC_EN
    test_sbc;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
